mul_sequencer: RTL and testbench

//  Multi-cycle shift-and-add multiply sequencer beside the EX-stage ALU of the

---
 rtl/mul_sequencer.sv | 99 +++++++++
 tb/tb_mul_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Shift-and-add MUL/UMULH sequencer beside the EX ALU: N BUSY cycles after accept, then a one-cycle done pulse.
// stall freezes IF/ID/EX during the accept cycle and the BUSY cycles; it is low in DONE so the result can be captured.
module mul_sequencer #(
  parameter int N     = 64,
  parameter int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [10:0]  funct,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] result
);

  localparam logic [10:0]      FUNCT_MUL   = 11'b10011011000;
  localparam logic [10:0]      FUNCT_UMULH = 11'b10011011110;
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             is_mul;
  logic             accept;
  logic             finish;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_nxt;
  logic [2*N-1:0]   mcand;
  logic [N-1:0]     mplier;
  logic [CNT_W-1:0] count;
  logic             hi_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    is_mul    = start && ((funct == FUNCT_MUL) || (funct == FUNCT_UMULH));
    stall     = (state == BUSY) || ((state == IDLE) && is_mul);
    acc_nxt   = mplier[0] ? acc + mcand : acc;
    // flush overrides everything, including a back-to-back accept in DONE
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (is_mul) state_nxt = BUSY;
        BUSY:    if (count == LAST) state_nxt = DONE;
        DONE:    state_nxt = is_mul ? BUSY : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    accept = (state != BUSY) && (state_nxt == BUSY);
    finish = (state == BUSY) && (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      hi_sel <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        hi_sel <= (funct == FUNCT_UMULH);
        acc    <= '0;
        count  <= '0;
      end else if (state == BUSY) begin
        // fixed latency: keep iterating even once the multiplier is exhausted
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
      end
      if (finish) begin
        result <= hi_sel ? acc_nxt[2*N-1:N] : acc_nxt[N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed cases plus random traffic against a product-level reference model.
module tb_mul_sequencer;

  localparam int N = 64;
  localparam logic [10:0] F_MUL   = 11'b10011011000;
  localparam logic [10:0] F_UMULH = 11'b10011011110;
  localparam logic [10:0] F_ADD   = 11'b10001011000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [10:0]   funct;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          flush;
  logic          stall;
  logic          done;
  logic [N-1:0]  result;

  mul_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference model: an op accepted at edge k finishes at edge k+N with the full 2N-bit product.
  logic          m_inflight;
  logic          m_done;
  logic [N-1:0]  m_result;
  logic [N-1:0]  m_pend;
  logic [127:0]  m_prod;
  longint        m_edge;
  longint        m_finish;

  function automatic logic is_mul_f(input logic s, input logic [10:0] f);
    return s && (f == F_MUL || f == F_UMULH);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_inflight = 1'b0;
      m_done     = 1'b0;
      m_result   = '0;
      m_pend     = '0;
      m_edge     = 0;
      m_finish   = 0;
    end else begin
      m_edge = m_edge + 1;
      if (flush) begin
        m_inflight = 1'b0;
        m_done     = 1'b0;
      end else if (!m_inflight && is_mul_f(start, funct)) begin
        m_prod     = {64'd0, a} * {64'd0, b};
        m_pend     = (funct == F_UMULH) ? m_prod[127:64] : m_prod[63:0];
        m_inflight = 1'b1;
        m_finish   = m_edge + N;
        m_done     = 1'b0;
      end else if (m_inflight && m_edge == m_finish) begin
        m_inflight = 1'b0;
        m_done     = 1'b1;
        m_result   = m_pend;
      end else begin
        m_done = 1'b0;
      end
    end
  end

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic last_stall;
  logic last_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare every output against the model mid-cycle, then step past the next edge.
  task automatic cycle();
    logic exp_stall;
    @(negedge clk);
    exp_stall = m_inflight || (!m_inflight && !m_done && is_mul_f(start, funct));
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("done", 64'(done), 64'(m_done));
    chk("result", result, m_result);
    last_stall = stall;
    last_done  = done;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic [10:0] f,
                        output logic [63:0] res, output int lat);
    a = ia; b = ib; funct = f; start = 1'b1; lat = 0;
    cycle();
    start = 1'b0;
    for (int i = 2; i <= 200 && lat == 0; i++) begin
      cycle();
      if (last_done) lat = i;
    end
    res = result;
    if (lat == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL op_timeout: got no done within 200 cycles, expected done in cycle %0d", N + 2);
    end
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    int          stall_cnt;
    int          done_at;
    int          done_cnt;
    int          d1;
    logic [63:0] r1;

    reset = 1'b0; start = 1'b0; funct = '0; a = '0; b = '0; flush = 1'b0;
    cycle();
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    reset = 1'b1;
    cycle();

    // 3*5: stall over accept + N BUSY cycles, done in the following cycle
    a = 64'd3; b = 64'd5; funct = F_MUL; start = 1'b1;
    stall_cnt = 0; done_at = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 2) start = 1'b0;
      cycle();
      if (last_stall) stall_cnt++;
      if (last_done && done_at == 0) done_at = i;
    end
    chk("t1_stall_cycles", 64'(stall_cnt), 64'd65);
    chk("t1_done_cycle", 64'(done_at), 64'd66);
    chk("t1_result_held", result, 64'd15);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, F_UMULH, res, lat);
    chk("t2_umulh", res, 64'd1);
    chk("t2_umulh_latency", 64'(lat), 64'd66);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, F_MUL, res, lat);
    chk("t2_mul", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F_MUL, res, lat);
    chk("t3_mul", res, 64'd1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F_UMULH, res, lat);
    chk("t3_umulh", res, 64'hFFFF_FFFF_FFFF_FFFE);

    // Non-multiply funct is left to the ALU
    a = 64'd11; b = 64'd13; funct = F_ADD; start = 1'b1;
    stall_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) start = 1'b0;
      cycle();
      if (last_stall) stall_cnt++;
      if (last_done) done_cnt++;
    end
    chk("t4_add_stall", 64'(stall_cnt), 64'd0);
    chk("t4_add_done", 64'(done_cnt), 64'd0);

    // Flush in the 20th BUSY cycle
    a = 64'd9; b = 64'd9; funct = F_MUL; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (19) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    chk("t5_stall_after_flush", 64'(last_stall), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (last_done) done_cnt++;
    end
    chk("t5_no_done_after_flush", 64'(done_cnt), 64'd0);
    chk("t5_result_kept", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'd7, 64'd6, F_MUL, res, lat);
    chk("t5_mul_7x6", res, 64'd42);
    chk("t5_latency", 64'(lat), 64'd66);

    // Async reset in the middle of BUSY
    a = 64'd9; b = 64'd9; funct = F_MUL; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (30) cycle();
    reset = 1'b0;
    #2;
    chk("t5_rst_stall", 64'(stall), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_result", result, 64'd0);
    cycle();
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (last_done) done_cnt++;
    end
    chk("t5_no_done_after_reset", 64'(done_cnt), 64'd0);

    // Back-to-back: start held so the second MUL is accepted in DONE
    a = 64'd2; b = 64'd3; funct = F_MUL; start = 1'b1;
    cycle();
    a = 64'd4; b = 64'd5;
    done_cnt = 0; d1 = 0; done_at = 0; r1 = '0;
    for (int i = 2; i <= 200 && done_cnt < 2; i++) begin
      cycle();
      if (last_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          d1 = i;
          r1 = result;
          start = 1'b0;
        end else begin
          done_at = i;
        end
      end
    end
    chk("t6_first_result", r1, 64'd6);
    chk("t6_second_result", result, 64'd20);
    chk("t6_gap", 64'(done_at - d1), 64'd65);

    // Random traffic, including held starts, flushes and other funct codes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: funct = F_MUL;
          1: funct = F_UMULH;
          2: funct = F_ADD;
          default: funct = 11'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: a = 64'hFFFF_FFFF_FFFF_FFFF;
          1: a = 64'($urandom_range(0, 255));
          default: a = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 3))
          0: b = 64'hFFFF_FFFF_FFFF_FFFF;
          1: b = 64'($urandom_range(0, 255));
          default: b = {$urandom, $urandom};
        endcase
      end
      start = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 63) == 0);
      cycle();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (70) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
